multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core datapath. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath enables and mux selects: PC, instruction register, ALU operands, ALU-out register, register file and write-back. It also owns the shared memory-port request/ready handshake, with a timeout, and traps on illegal opcodes or bus timeout. It sits beside the datapath that holds the IR, the immediate generator, the ALU and the register file.

## Interface
Parameters:
- MEM_WAIT_MAX, 15: maximum request cycles without ready before a bus-error trap (≥1).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_instr  in  32  IR contents; only [6:0] is decoded
- i_br_taken  in  1  branch comparator result for the current IR
- i_mem_ready  in  1  memory port accepts or returns data this cycle
- o_mem_req  out  1  memory request
- o_mem_we  out  1  store strobe, valid with o_mem_req
- o_addr_sel  out  1  memory address select: 0 = PC, 1 = ALU-out
- o_ir_we  out  1  latch memory read data into the IR
- o_pc_we  out  1  PC write enable
- o_pc_sel  out  1  next-PC select: 0 = PC+4, 1 = ALU-out (JALR LSB clear is done in the datapath)
- o_alu_a_sel  out  1  ALU A operand: 0 = rs1, 1 = PC, with rs1 forced to 0 for LUI
- o_alu_b_sel  out  1  ALU B operand: 0 = rs2, 1 = immediate
- o_aluout_we  out  1  ALU-out register enable
- o_rf_we  out  1  register-file write enable
- o_wb_sel  out  2  write-back source: 0 = ALU-out, 1 = memory data, 2 = PC+4
- o_illegal  out  1  sticky illegal-opcode flag
- o_bus_err  out  1  sticky memory-timeout flag
- o_state  out  3  current state encoding, for debug

## Operation
States and encodings: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.

While i_rst_n is low:
- state is RST.
- Every output is 0.

State transitions and outputs:
- **RST** → FETCH unconditionally. All outputs are 0.
- **FETCH:**
  - o_mem_req=1, o_addr_sel=0, o_mem_we=0.
  - On i_mem_ready: o_ir_we=1 in the same cycle, go to DECODE.
- **DECODE:**
  - Classify i_instr[6:0] into a registered class: LOAD, STORE, BRANCH, JAL, JALR, OP, OPIMM, LUI or AUIPC.
  - Any other opcode: set o_illegal, go to TRAP.
  - Otherwise go to EXEC.
- **EXEC:**
  - o_aluout_we=1. Operand selects:
    - a_sel=1 for AUIPC, JAL and BRANCH.
    - b_sel=0 only for OP.
  - BRANCH: o_pc_we=1, o_pc_sel=i_br_taken, go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other classes: go to WB.
- **MEM:**
  - o_mem_req=1, o_addr_sel=1, o_mem_we=1 for STORE only.
  - On i_mem_ready:
    - LOAD goes to WB.
    - STORE asserts o_pc_we=1 with o_pc_sel=0, then goes to FETCH.
- **WB:**
  - o_rf_we=1.
  - o_wb_sel: 1 for LOAD, 2 for JAL and JALR, 0 otherwise.
  - o_pc_we=1; o_pc_sel=1 for JAL and JALR, 0 otherwise.
  - Go to FETCH.
- **TRAP:** absorbing until reset. All enables and the request are 0; the flags hold.

Memory handshake:
- o_mem_req, o_addr_sel and o_mem_we stay stable from state entry until the cycle where i_mem_ready=1 is sampled. That cycle completes the transfer.
- The request drops in the next cycle.
- i_mem_ready is ignored while o_mem_req=0.

Timeout counter:
- Width is $clog2(MEM_WAIT_MAX+1). It clears on entry to FETCH or MEM.
- It increments on each request cycle with ready low.
- If the counter equals MEM_WAIT_MAX-1 and ready is low, go to TRAP and set o_bus_err.
- Net effect: ready on any of the first MEM_WAIT_MAX request cycles succeeds.

## Timing
- All outputs are combinational from the state, the class register and i_mem_ready/i_br_taken. No output depends on i_instr except in DECODE.
- Latency with zero-wait memory, counting from FETCH entry:
  - branch: 3 cycles
  - OP, OPIMM, LUI, AUIPC, JAL, JALR and STORE: 4 cycles
  - LOAD: 5 cycles
- Each memory wait cycle adds 1 cycle.
- Reset asserted mid-operation (for example in MEM with a request pending) drops every output in the same cycle, asynchronously. After release, the first cycle is RST, then FETCH.
- Flags clear only on reset.

## Structure
- Package ctrl_pkg holds:
  - state_e enum with the fixed encodings
  - opcode localparams
  - iclass_e enum
  - wb_sel localparams (ALU/MEM/PC4)
- Sub-module ctrl_decode: purely combinational; maps opcode → {iclass_e, legal}. The FSM, counter and output logic stay in multicycle_ctrl.

## Test plan
- **ADDI** 0x00500093, ready always 1 → states 1,2,3,5. EXEC: b_sel=1, aluout_we=1. WB: rf_we=1, wb_sel=0, pc_we=1, pc_sel=0.
- **LW** 0x0000A103, ready low for 2 MEM cycles → mem_req/addr_sel=1 for 3 cycles, mem_we=0. Next cycle WB with wb_sel=1. Total 7 cycles.
- **BEQ** 0x00000463:
  - with i_br_taken=1 → EXEC: pc_we=1, pc_sel=1, a_sel=1; next state FETCH. rf_we never asserts.
  - with i_br_taken=0 → pc_sel=0.
- **JAL** 0x008000EF → WB: wb_sel=2, pc_sel=1, rf_we=1.
- **Illegal** 0x00000000 → TRAP (o_state=6), o_illegal=1, no further mem_req. Held until reset.
- **MEM_WAIT_MAX=4**, ready never asserted in FETCH → exactly 4 request cycles, then TRAP with o_bus_err=1. Separately, assert reset during a pending MEM request → all outputs 0 immediately; restart sequence RST → FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    IC_LOAD, IC_STORE, IC_BRANCH, IC_JAL, IC_JALR,
    IC_OP, IC_OPIMM, IC_LUI, IC_AUIPC
  } iclass_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps IR[6:0] to an instruction class plus a legal bit.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_e    iclass,
  output logic       legal
);

  // unknown opcodes fall through to legal=0; class is don't-care then
  always_comb begin
    iclass = IC_OP;
    legal  = 1'b1;
    case (opcode)
      OPC_LOAD:   iclass = IC_LOAD;
      OPC_STORE:  iclass = IC_STORE;
      OPC_BRANCH: iclass = IC_BRANCH;
      OPC_JAL:    iclass = IC_JAL;
      OPC_JALR:   iclass = IC_JALR;
      OPC_OP:     iclass = IC_OP;
      OPC_OPIMM:  iclass = IC_OPIMM;
      OPC_LUI:    iclass = IC_LUI;
      OPC_AUIPC:  iclass = IC_AUIPC;
      default:    legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing, memory
// handshake with timeout, and sticky trap flags.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_br_taken,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_addr_sel,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic        o_pc_sel,
  output logic        o_alu_a_sel,
  output logic        o_alu_b_sel,
  output logic        o_aluout_we,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_illegal,
  output logic        o_bus_err,
  output logic [2:0]  o_state
);

  localparam int             CW        = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

  state_e        state, state_nxt;
  iclass_e       iclass, dec_class;
  logic          dec_legal;
  logic [CW-1:0] wait_cnt;
  logic          illegal, bus_err, set_ill, set_berr;
  logic          wait_last;
  logic          instr_unused;

  // only the opcode field is decoded here; the rest belongs to the datapath
  assign instr_unused = ^i_instr[31:7];

  ctrl_decode u_dec (
    .opcode (i_instr[6:0]),
    .iclass (dec_class),
    .legal  (dec_legal)
  );

  assign wait_last = (wait_cnt == WAIT_LAST) && !i_mem_ready;
  assign o_illegal = illegal;
  assign o_bus_err = bus_err;
  assign o_state   = state;

  // state, latched class, request wait counter and sticky trap flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_RST;
      iclass   <= IC_OP;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) iclass <= dec_class;
      if (set_ill)  illegal <= 1'b1;
      if (set_berr) bus_err <= 1'b1;
      // restart the wait budget on every entry to a requesting state
      if (state_nxt != state && (state_nxt == ST_FETCH || state_nxt == ST_MEM))
        wait_cnt <= '0;
      else if (o_mem_req && !i_mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // next state and datapath controls, all decoded from the current state
  always_comb begin
    state_nxt   = state;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_addr_sel  = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = 1'b0;
    o_alu_a_sel = 1'b0;
    o_alu_b_sel = 1'b0;
    o_aluout_we = 1'b0;
    o_rf_we     = 1'b0;
    o_wb_sel    = WB_ALU;
    set_ill     = 1'b0;
    set_berr    = 1'b0;
    unique case (state)
      ST_RST: state_nxt = ST_FETCH;
      ST_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_we   = 1'b1;
          state_nxt = ST_DECODE;
        end else if (wait_last) begin
          set_berr  = 1'b1;
          state_nxt = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (dec_legal) state_nxt = ST_EXEC;
        else begin
          set_ill   = 1'b1;
          state_nxt = ST_TRAP;
        end
      end
      ST_EXEC: begin
        o_aluout_we = 1'b1;
        o_alu_a_sel = iclass inside {IC_AUIPC, IC_JAL, IC_BRANCH};
        o_alu_b_sel = (iclass != IC_OP);
        if (iclass == IC_BRANCH) begin
          o_pc_we   = 1'b1;
          o_pc_sel  = i_br_taken;
          state_nxt = ST_FETCH;
        end else if (iclass inside {IC_LOAD, IC_STORE}) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        o_mem_req  = 1'b1;
        o_addr_sel = 1'b1;
        o_mem_we   = (iclass == IC_STORE);
        if (i_mem_ready) begin
          if (iclass == IC_STORE) begin
            o_pc_we   = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (wait_last) begin
          set_berr  = 1'b1;
          state_nxt = ST_TRAP;
        end
      end
      ST_WB: begin
        o_rf_we   = 1'b1;
        o_pc_we   = 1'b1;
        o_pc_sel  = iclass inside {IC_JAL, IC_JALR};
        if (iclass == IC_LOAD)                   o_wb_sel = WB_MEM;
        else if (iclass inside {IC_JAL, IC_JALR}) o_wb_sel = WB_PC4;
        state_nxt = ST_FETCH;
      end
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: a per-instruction trace generator predicts every
// cycle's outputs from the instruction, branch outcome and memory waits.
module tb_multicycle_ctrl;

  localparam int MAXW = 4;

  logic        i_clk, i_rst_n, i_br_taken, i_mem_ready;
  logic [31:0] i_instr;
  logic        o_mem_req, o_mem_we, o_addr_sel, o_ir_we, o_pc_we, o_pc_sel;
  logic        o_alu_a_sel, o_alu_b_sel, o_aluout_we, o_rf_we, o_illegal, o_bus_err;
  logic [1:0]  o_wb_sel;
  logic [2:0]  o_state;
  logic [16:0] obs;

  int nassert = 0;
  int nfail   = 0;
  logic m_ill, m_berr;

  typedef struct {
    logic        rdy;
    logic [16:0] exp;
    string       tag;
  } step_t;
  step_t q[$];

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_br_taken(i_br_taken),
    .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_addr_sel(o_addr_sel), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel),
    .o_alu_a_sel(o_alu_a_sel), .o_alu_b_sel(o_alu_b_sel), .o_aluout_we(o_aluout_we),
    .o_rf_we(o_rf_we), .o_wb_sel(o_wb_sel), .o_illegal(o_illegal), .o_bus_err(o_bus_err),
    .o_state(o_state)
  );

  assign obs = {o_state, o_mem_req, o_mem_we, o_addr_sel, o_ir_we, o_pc_we, o_pc_sel,
                o_alu_a_sel, o_alu_b_sel, o_aluout_we, o_rf_we, o_wb_sel, o_illegal, o_bus_err};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // field order: state req we addr_sel ir_we pc_we pc_sel a b aluout_we rf_we wb_sel ill berr
  function automatic logic [16:0] mk(logic [2:0] st, logic req, logic we, logic asel,
                                     logic irwe, logic pcwe, logic pcsel, logic a, logic b,
                                     logic aluwe, logic rfwe, logic [1:0] wb);
    return {st, req, we, asel, irwe, pcwe, pcsel, a, b, aluwe, rfwe, wb, m_ill, m_berr};
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input logic [16:0] e, input string t);
    step_t s;
    s.rdy = r; s.exp = e; s.tag = t;
    q.push_back(s);
  endtask

  task automatic chk(input string tag, input logic [16:0] act, input logic [16:0] exp);
    nassert++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  task automatic trap_steps();
    for (int i = 0; i < 3; i++) push(rb(), mk(6,0,0,0,0,0,0,0,0,0,0,2'd0), "trap_hold");
  endtask

  // Expected trace of one instruction: wf/wm are ready-low cycles before the
  // fetch / data transfer; MAXW or more of them means a bus timeout.
  task automatic model(input logic [31:0] ins, input logic br, input int wf, input int wm);
    bit ok = 1, ld = 0, st = 0, bra = 0, jmp = 0, op = 0, pcrel = 0;
    logic [1:0] wb;
    case (ins[6:0])
      7'h03: ld = 1;
      7'h23: st = 1;
      7'h63: bra = 1;
      7'h6f: begin jmp = 1; pcrel = 1; end
      7'h67: jmp = 1;
      7'h33: op = 1;
      7'h13, 7'h37: ;
      7'h17: pcrel = 1;
      default: ok = 0;
    endcase
    for (int i = 0; i < wf && i < MAXW; i++) push(1'b0, mk(1,1,0,0,0,0,0,0,0,0,0,2'd0), "fetch_wait");
    if (wf >= MAXW) begin m_berr = 1; trap_steps(); return; end
    push(1'b1, mk(1,1,0,0,1,0,0,0,0,0,0,2'd0), "fetch_done");
    push(rb(), mk(2,0,0,0,0,0,0,0,0,0,0,2'd0), "decode");
    if (!ok) begin m_ill = 1; trap_steps(); return; end
    push(rb(), mk(3,0,0,0,0,bra,bra & br,bra | pcrel,!op,1,0,2'd0), "exec");
    if (bra) return;
    if (ld || st) begin
      for (int i = 0; i < wm && i < MAXW; i++) push(1'b0, mk(4,1,st,1,0,0,0,0,0,0,0,2'd0), "mem_wait");
      if (wm >= MAXW) begin m_berr = 1; trap_steps(); return; end
      push(1'b1, mk(4,1,st,1,0,st,0,0,0,0,0,2'd0), "mem_done");
      if (st) return;
    end
    wb = ld ? 2'd1 : (jmp ? 2'd2 : 2'd0);
    push(rb(), mk(5,0,0,0,0,1,jmp,0,0,0,1,wb), "wb");
  endtask

  task automatic run_q();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge i_clk);
      i_mem_ready = s.rdy;
      #1 chk(s.tag, obs, s.exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i_mem_ready = 1'b0;
    m_ill = 0; m_berr = 0;
    #1 chk("reset_hold", obs, 17'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 chk("rst_state", obs, 17'd0);
  endtask

  task automatic instr(input logic [31:0] ins, input logic br, input int wf, input int wm);
    i_instr = ins; i_br_taken = br;
    model(ins, br, wf, wm);
    run_q();
    if (m_ill || m_berr) do_reset();
  endtask

  logic [6:0] legal_ops [9] = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17};
  logic [6:0] bad_ops   [4] = '{7'h00, 7'h7f, 7'h0f, 7'h73};

  initial begin
    logic [31:0] ins;
    int wf, wm;
    i_rst_n = 1'b0; i_mem_ready = 1'b0; i_instr = '0; i_br_taken = 1'b0;
    m_ill = 0; m_berr = 0;
    do_reset();

    instr(32'h00500093, 1'b0, 0, 0);   // ADDI
    instr(32'h0000A103, 1'b0, 0, 2);   // LW with two MEM waits
    instr(32'h00000463, 1'b1, 0, 0);   // BEQ taken
    instr(32'h00000463, 1'b0, 1, 0);   // BEQ not taken, one fetch wait
    instr(32'h008000EF, 1'b0, 0, 0);   // JAL
    instr(32'h0020A023, 1'b0, 0, 1);   // SW
    instr(32'h000080E7, 1'b0, 3, 0);   // JALR, last allowed fetch wait
    instr(32'h123452B7, 1'b0, 0, 0);   // LUI
    instr(32'h00001317, 1'b0, 0, 0);   // AUIPC
    instr(32'h002081B3, 1'b0, 0, 0);   // ADD
    instr(32'h0000A103, 1'b0, 0, 3);   // LW, last allowed MEM wait
    instr(32'h00000000, 1'b0, 0, 0);   // illegal -> trap, then reset
    instr(32'h00500093, 1'b0, MAXW, 0); // fetch timeout
    instr(32'h0020A023, 1'b0, 0, MAXW); // store timeout

    // asynchronous reset in the middle of a pending MEM request
    i_instr = 32'h0000A103; i_br_taken = 1'b0;
    model(32'h0000A103, 1'b0, 0, 3);
    void'(q.pop_back()); void'(q.pop_back()); void'(q.pop_back());
    run_q();
    #2 i_rst_n = 1'b0;
    #1 chk("async_rst", obs, 17'd0);
    do_reset();
    instr(32'h00500093, 1'b0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 19) == 0) ins[6:0] = bad_ops[$urandom_range(0, 3)];
      else                            ins[6:0] = legal_ops[$urandom_range(0, 8)];
      wf = ($urandom_range(0, 24) == 0) ? MAXW : $urandom_range(0, 3);
      wm = ($urandom_range(0, 24) == 0) ? MAXW : $urandom_range(0, 3);
      instr(ins, rb(), wf, wm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
